latch_shift_tx: RTL



---
 rtl/latch_shift_tx_if.sv | 27 ++
 rtl/latch_shift_tx.sv | 134 +++++++++++++
 2 files changed

// File: rtl/latch_shift_tx_if.sv
// Word-source handshake plus latch-chain drive lines for latch_shift_tx.
// Latency: none (wires only).
// Backpressure: in_ready from the slave side gates in_valid from the master side.
interface latch_shift_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              d;
  logic              c;
  logic              le;
  logic              busy;
  logic              done;

  // Word source / observer side
  modport master (
    output in_data, in_valid,
    input  in_ready, d, c, le, busy, done
  );

  // Transmitter side
  modport slave (
    input  in_data, in_valid,
    output in_ready, d, c, le, busy, done
  );
endinterface

// File: rtl/latch_shift_tx.sv
// Serializes a parallel word onto a latch chain: d qualified by strobe c, then an le load pulse.
// Latency: first c rise HALF_PER+1 cycles after capture; whole transfer (2*DATA_W+1)*HALF_PER cycles.
// Backpressure: in_ready only in IDLE; in_valid while busy is dropped, nothing is queued.
module latch_shift_tx #(
  parameter int DATA_W    = 8,
  parameter int HALF_PER  = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic           clk,
  input  logic           rst,
  latch_shift_tx_if.slave bus
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int PW = $clog2(HALF_PER + 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOAD} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  logic d_q, d_d;
  logic c_q, c_d;
  logic le_q, le_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic in_ready_q, in_ready_d;

  logic phase_last;
  logic cur_bit;

  assign phase_last = (phase_q == PW'(HALF_PER - 1));

  // State register and all registered outputs; reset drops any word in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      d_q        <= 1'b0;
      c_q        <= 1'b0;
      le_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      d_q        <= d_d;
      c_q        <= c_d;
      le_q       <= le_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next state: each non-idle phase lasts HALF_PER cycles; the shift happens on HIGH -> SETUP
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        // in_ready_q (not just the state) gates capture so the first post-reset cycle never accepts
        if (bus.in_valid && in_ready_q) begin
          shreg_d = bus.in_data;
          bit_d   = '0;
          phase_d = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = HIGH;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      HIGH: begin
        if (phase_last) begin
          phase_d = '0;
          if (bit_q == BW'(DATA_W - 1)) begin
            state_d = LOAD;
          end else begin
            state_d = SETUP;
            bit_d   = bit_q + BW'(1);
            shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      LOAD: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so they are registered yet line up with the state
  always_comb begin
    cur_bit    = (MSB_FIRST != 0) ? shreg_d[DATA_W-1] : shreg_d[0];
    d_d        = ((state_d == SETUP) || (state_d == HIGH)) ? cur_bit : 1'b0;
    c_d        = (state_d == HIGH);
    le_d       = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
    done_d     = (state_d == LOAD) && (phase_d == PW'(HALF_PER - 1));
  end

  assign bus.d        = d_q;
  assign bus.c        = c_q;
  assign bus.le       = le_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.in_ready = in_ready_q;

endmodule
